// File: rtl/xbar_arbiter.sv
// rtl/xbar_arbiter.sv - control plane for a 2-master x 2-slave request/ack crossbar
//
// Purpose: decodes each master's target slave from address bit SLV_BIT and runs one
// round-robin arbiter FSM (IDLE/BUSY) per slave. A grant is held until the slave acks
// or the owning master drops req. The block drives the switch-matrix selects and
// req gating, and routes slave acks and rdata selects back to the owning master.
//
// Optional feature: define XBAR_TIMEOUT_EN to add a per-slave busy timeout that
// force-releases a grant after TIMEOUT_CYC busy cycles without ack (s*_tout pulse).
// Without it, BUSY waits indefinitely and s0_tout/s1_tout are tied low.
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous active-low reset
//   m0_req/m1_req   master requests, held until the matching m*_ack
//   m0_addr/m1_addr master addresses, bit SLV_BIT selects the slave
//   s0_ack/s1_ack   single-cycle slave acks
//   s0_sel/s1_sel   master feeding each slave (0 = m0, 1 = m1), holds in IDLE
//   s0_req/s1_req   gated requests to the slaves
//   m0_ack/m1_ack   acks routed back to the masters
//   m0_rsel/m1_rsel slave whose rdata returns to each master
//   s0_tout/s1_tout per-slave timeout pulses
`timescale 1ns/1ps
module xbar_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int SLV_BIT     = 31,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              s0_ack,
  input  logic              s1_ack,
  output logic              s0_sel,
  output logic              s1_sel,
  output logic              s0_req,
  output logic              s1_req,
  output logic              m0_ack,
  output logic              m1_ack,
  output logic              m0_rsel,
  output logic              m1_rsel,
  output logic              s0_tout,
  output logic              s1_tout
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  logic [1:0] req;
  logic [1:0] tgt;
  logic [1:0] s_ack;
  logic [1:0] busy;
  logic [1:0] own;
  logic [1:0] grant_vld;
  logic [1:0] winner;
  logic [1:0] s_req;
  logic [1:0] tout;
  logic [1:0] m_ack;
  logic [1:0] m_rsel_q;
  logic       unused_addr;

  assign req   = {m1_req, m0_req};
  assign tgt   = {m1_addr[SLV_BIT], m0_addr[SLV_BIT]};
  assign s_ack = {s1_ack, s0_ack};

  // Only SLV_BIT matters here; the rest of the address belongs to the datapath.
  assign unused_addr = ^{m0_addr, m1_addr};

  for (genvar j = 0; j < 2; j++) begin : g_slv
    localparam logic SLV_ID = 1'(j);

    state_t state_q, state_d;
    logic   own_q, own_d;
    logic   ptr_q, ptr_d;
    logic   cand0, cand1;
    logic   owner_req;
    logic   tmo;
    logic   gv, win;
    logic   busy_l, s_req_l, tout_l;

    assign cand0     = req[0] & (tgt[0] == SLV_ID);
    assign cand1     = req[1] & (tgt[1] == SLV_ID);
    // Once granted, only the owner's req matters; its address is not re-decoded.
    assign owner_req = req[own_q];

`ifdef XBAR_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;

    // Held at zero in IDLE so every BUSY entry starts counting from 0.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
      end else if (state_q == IDLE) begin
        cnt_q <= '0;
      end else if (!s_ack[j]) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign tmo = (cnt_q == CNT_W'(TIMEOUT_CYC));
`else
    assign tmo = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= IDLE;
        own_q   <= 1'b0;
        ptr_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        own_q   <= own_d;
        ptr_q   <= ptr_d;
      end
    end

    // Next-state logic
    always_comb begin
      state_d = state_q;
      own_d   = own_q;
      ptr_d   = ptr_q;
      gv      = 1'b0;
      // Contention resolves to the pointer; otherwise the lone candidate wins.
      win     = (cand0 & cand1) ? ptr_q : cand1;
      case (state_q)
        IDLE: begin
          if (cand0 | cand1) begin
            gv      = 1'b1;
            own_d   = win;
            state_d = BUSY;
          end
        end
        BUSY: begin
          // Ack beats abort and timeout; abort leaves the pointer untouched.
          if (s_ack[j]) begin
            state_d = IDLE;
            ptr_d   = ~own_q;
          end else if (!owner_req) begin
            state_d = IDLE;
          end else if (tmo) begin
            state_d = IDLE;
            ptr_d   = ~own_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Output logic
    always_comb begin
      busy_l  = (state_q == BUSY);
      s_req_l = busy_l & owner_req;
      tout_l  = busy_l & owner_req & ~s_ack[j] & tmo;
    end

    assign busy[j]      = busy_l;
    assign s_req[j]     = s_req_l;
    assign tout[j]      = tout_l;
    assign own[j]       = own_q;
    assign grant_vld[j] = gv;
    assign winner[j]    = win;
  end

  // Ack routing back to the owner; stray acks in IDLE are dropped.
  always_comb begin
    m_ack = 2'b00;
    for (int j = 0; j < 2; j++) begin
      if (busy[j] && s_ack[j]) begin
        m_ack[own[j]] = 1'b1;
      end
    end
  end

  // A master targets one slave, so at most one slave can grant it per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_rsel_q <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (grant_vld[0] && (winner[0] == 1'(i))) begin
          m_rsel_q[i] <= 1'b0;
        end else if (grant_vld[1] && (winner[1] == 1'(i))) begin
          m_rsel_q[i] <= 1'b1;
        end
      end
    end
  end

  assign s0_sel  = own[0];
  assign s1_sel  = own[1];
  assign s0_req  = s_req[0];
  assign s1_req  = s_req[1];
  assign m0_ack  = m_ack[0];
  assign m1_ack  = m_ack[1];
  assign m0_rsel = m_rsel_q[0];
  assign m1_rsel = m_rsel_q[1];
  assign s0_tout = tout[0];
  assign s1_tout = tout[1];

endmodule

// File: tb/tb_xbar_arbiter.sv
// tb/tb_xbar_arbiter.sv - directed self-checking bench for xbar_arbiter
`timescale 1ns/1ps
module tb_xbar_arbiter;

`ifdef XBAR_TIMEOUT_EN
  localparam int TC = 4;
`else
  localparam int TC = 255;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic        s0_ack = 1'b0, s1_ack = 1'b0;
  logic        s0_sel, s1_sel, s0_req, s1_req;
  logic        m0_ack, m1_ack, m0_rsel, m1_rsel, s0_tout, s1_tout;
  logic [9:0]  outs;

  int checks = 0;
  int errors = 0;

  assign outs = {s0_sel, s1_sel, s0_req, s1_req, m0_ack, m1_ack, m0_rsel, m1_rsel, s0_tout, s1_tout};

  always #5 clk = ~clk;

  xbar_arbiter #(
    .ADDR_W(32), .SLV_BIT(31), .TIMEOUT_CYC(TC), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m1_req(m1_req), .m1_addr(m1_addr),
    .s0_ack(s0_ack), .s1_ack(s1_ack),
    .s0_sel(s0_sel), .s1_sel(s1_sel), .s0_req(s0_req), .s1_req(s1_req),
    .m0_ack(m0_ack), .m1_ack(m1_ack), .m0_rsel(m0_rsel), .m1_rsel(m1_rsel),
    .s0_tout(s0_tout), .s1_tout(s1_tout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; s0_ack = 1'b0; s1_ack = 1'b0;
    m0_addr = '0; m1_addr = '0;
    step();
    settle();
    reset = 1'b1;
    settle();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h0000_0010;
    step(); step(); settle();
    checks++; if (outs !== 10'b0) begin errors++; $display("FAIL reset_outs: got %b expected %b", outs, 10'b0); end
    reset = 1'b1;
    step();
    checks++; if ({s0_sel, s0_req, s1_req} !== 3'b010) begin errors++; $display("FAIL release_grant: got %b expected 010", {s0_sel, s0_req, s1_req}); end
    m0_req = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h0000_0010;
    step();
    checks++; if ({s0_sel, s0_req} !== 2'b01) begin errors++; $display("FAIL basic_grant: got %b expected 01", {s0_sel, s0_req}); end
    step(); step(); step();
    s0_ack = 1'b1; settle();
    checks++; if ({m0_ack, m1_ack, m0_rsel} !== 3'b100) begin errors++; $display("FAIL basic_ack: got %b expected 100", {m0_ack, m1_ack, m0_rsel}); end
    step();
    s0_ack = 1'b0; m0_req = 1'b0; settle();
    checks++; if ({s0_req, m0_ack} !== 2'b00) begin errors++; $display("FAIL basic_release: got %b expected 00", {s0_req, m0_ack}); end
  endtask

  task automatic test_rr_slave1();
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h8000_0000;
    m1_req = 1'b1; m1_addr = 32'h8000_0000;
    step(); settle();
    checks++; if ({s1_sel, s1_req, m0_rsel} !== 3'b011) begin errors++; $display("FAIL rr_first_grant: got %b expected 011", {s1_sel, s1_req, m0_rsel}); end
    s1_ack = 1'b1; settle();
    checks++; if ({m0_ack, m1_ack} !== 2'b10) begin errors++; $display("FAIL rr_first_ack: got %b expected 10", {m0_ack, m1_ack}); end
    step();
    s1_ack = 1'b0; m0_req = 1'b0; settle();
    checks++; if (s1_req !== 1'b0) begin errors++; $display("FAIL rr_gap: got %b expected 0", s1_req); end
    step(); settle();
    checks++; if ({s1_sel, s1_req, m1_rsel} !== 3'b111) begin errors++; $display("FAIL rr_second_grant: got %b expected 111", {s1_sel, s1_req, m1_rsel}); end
    s1_ack = 1'b1; settle();
    checks++; if ({m0_ack, m1_ack} !== 2'b01) begin errors++; $display("FAIL rr_second_ack: got %b expected 01", {m0_ack, m1_ack}); end
    step();
    s1_ack = 1'b0; m1_req = 1'b0; settle();
  endtask

  task automatic test_alternate();
    logic exp_sel;
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h0000_0100;
    m1_req = 1'b1; m1_addr = 32'h0000_0200;
    for (int k = 0; k < 4; k++) begin
      exp_sel = (k % 2 == 1);
      step(); settle();
      checks++; if ({s0_sel, s0_req} !== {exp_sel, 1'b1}) begin errors++; $display("FAIL alt_grant_%0d: got %b expected %b", k, {s0_sel, s0_req}, {exp_sel, 1'b1}); end
      s0_ack = 1'b1; settle();
      checks++; if ({m1_ack, m0_ack} !== {exp_sel, ~exp_sel}) begin errors++; $display("FAIL alt_ack_%0d: got %b expected %b", k, {m1_ack, m0_ack}, {exp_sel, ~exp_sel}); end
      step();
      s0_ack = 1'b0; settle();
      checks++; if (s0_req !== 1'b0) begin errors++; $display("FAIL alt_gap_%0d: got %b expected 0", k, s0_req); end
    end
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic test_parallel();
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h0000_0004;
    m1_req = 1'b1; m1_addr = 32'h8000_0008;
    step(); settle();
    checks++; if ({s0_sel, s0_req, s1_sel, s1_req} !== 4'b0111) begin errors++; $display("FAIL par_grant: got %b expected 0111", {s0_sel, s0_req, s1_sel, s1_req}); end
    checks++; if ({m0_rsel, m1_rsel} !== 2'b01) begin errors++; $display("FAIL par_rsel: got %b expected 01", {m0_rsel, m1_rsel}); end
    s1_ack = 1'b1; settle();
    checks++; if ({m0_ack, m1_ack} !== 2'b01) begin errors++; $display("FAIL par_ack_s1: got %b expected 01", {m0_ack, m1_ack}); end
    step();
    s1_ack = 1'b0; m1_req = 1'b0; s0_ack = 1'b1; settle();
    checks++; if ({m0_ack, m1_ack, s1_req} !== 3'b100) begin errors++; $display("FAIL par_ack_s0: got %b expected 100", {m0_ack, m1_ack, s1_req}); end
    step();
    s0_ack = 1'b0; m0_req = 1'b0; settle();
    checks++; if ({s0_req, s1_req, m0_ack, m1_ack} !== 4'b0000) begin errors++; $display("FAIL par_idle: got %b expected 0000", {s0_req, s1_req, m0_ack, m1_ack}); end
  endtask

  task automatic test_abort_and_reset();
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h0000_0000;
    step();
    s0_ack = 1'b1;
    step();
    s0_ack = 1'b0; m0_req = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h0000_0040;
    step(); settle();
    checks++; if ({s0_sel, s0_req} !== 2'b11) begin errors++; $display("FAIL abort_grant: got %b expected 11", {s0_sel, s0_req}); end
    m1_req = 1'b0; settle();
    checks++; if ({s0_req, m1_ack} !== 2'b00) begin errors++; $display("FAIL abort_drop: got %b expected 00", {s0_req, m1_ack}); end
    step();
    s0_ack = 1'b1; settle();
    checks++; if ({m0_ack, m1_ack} !== 2'b00) begin errors++; $display("FAIL stray_ack: got %b expected 00", {m0_ack, m1_ack}); end
    s0_ack = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    step(); settle();
    checks++; if ({s0_sel, s0_req} !== 2'b11) begin errors++; $display("FAIL abort_ptr_kept: got %b expected 11", {s0_sel, s0_req}); end
    reset = 1'b0; settle();
    checks++; if (outs !== 10'b0) begin errors++; $display("FAIL midbusy_reset: got %b expected %b", outs, 10'b0); end
    step();
    checks++; if (outs !== 10'b0) begin errors++; $display("FAIL held_reset: got %b expected %b", outs, 10'b0); end
    m0_req = 1'b0; m1_req = 1'b0;
    reset = 1'b1; settle();
  endtask

`ifdef XBAR_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h8000_0000;
    step(); settle();
    for (int c = 0; c < 4; c++) begin
      checks++; if ({s1_tout, s1_req} !== 2'b01) begin errors++; $display("FAIL tout_wait_%0d: got %b expected 01", c, {s1_tout, s1_req}); end
      step(); settle();
    end
    checks++; if ({s1_tout, s1_req, m0_ack} !== 3'b110) begin errors++; $display("FAIL tout_pulse: got %b expected 110", {s1_tout, s1_req, m0_ack}); end
    step(); settle();
    checks++; if ({s1_tout, s1_req} !== 2'b00) begin errors++; $display("FAIL tout_release: got %b expected 00", {s1_tout, s1_req}); end
    step(); settle();
    for (int c = 0; c < 4; c++) begin
      step(); settle();
    end
    s1_ack = 1'b1; settle();
    checks++; if ({s1_tout, m0_ack} !== 2'b01) begin errors++; $display("FAIL tout_ack_wins: got %b expected 01", {s1_tout, m0_ack}); end
    step();
    s1_ack = 1'b0; m0_req = 1'b0; settle();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_rr_slave1();
    test_alternate();
    test_parallel();
    test_abort_and_reset();
`ifdef XBAR_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
